// File: rtl/cba_pkg.sv
// rtl/cba_pkg.sv - sizing helpers and stage record layout for the pipelined carry-bypass adder
package cba_pkg;

    function automatic int NUM_GROUPS(input int width, input int block_w);
        return width / block_w;
    endfunction

    function automatic int SLICE_W(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// Stage record: partial sum fills from the LSB end; operands ride along whole.
`define CBA_STAGE_T(W) struct packed { \
    logic           valid; \
    logic           carry; \
    logic [(W)-1:0] psum;  \
    logic [(W)-1:0] a;     \
    logic [(W)-1:0] b;     \
}

// File: rtl/carry_bypass_block.sv
// rtl/carry_bypass_block.sv - one ripple group whose carry-out bypasses the ripple when fully propagating
module carry_bypass_block #(
    parameter int BLOCK_W = 4
) (
    input  logic [BLOCK_W-1:0] a,
    input  logic [BLOCK_W-1:0] b,
    input  logic               cin,
    output logic [BLOCK_W-1:0] s,
    output logic               cout
);

    logic [BLOCK_W-1:0] w_p;
    logic [BLOCK_W-1:0] w_g;
    logic               w_ripple;

    assign w_p = a ^ b;
    assign w_g = a & b;

    always_comb begin
        s        = '0;
        w_ripple = cin;
        for (int i = 0; i < BLOCK_W; i++) begin
            s[i]     = w_p[i] ^ w_ripple;
            w_ripple = w_g[i] | (w_p[i] & w_ripple);
        end
    end

    assign cout = (&w_p) ? cin : w_ripple;

endmodule

// File: rtl/pipelined_carry_bypass_adder.sv
// rtl/pipelined_carry_bypass_adder.sv - elastic STAGES-deep carry-bypass adder; CBA_SIGNED_OVERFLOW_EN adds a signed overflow output
module pipelined_carry_bypass_adder
    import cba_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int BLOCK_W = 4,
    parameter int STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef CBA_SIGNED_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int S  = SLICE_W(WIDTH, STAGES);
    localparam int NG = NUM_GROUPS(S, BLOCK_W);

    typedef `CBA_STAGE_T(WIDTH) stage_t;

    if ((WIDTH % (BLOCK_W * STAGES)) != 0) begin : g_param_check
        $fatal(1, "WIDTH must be divisible by BLOCK_W*STAGES");
    end

    logic [STAGES-1:0] w_valid;
    logic [STAGES-1:0] w_up;
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_unload;
    logic              w_dn_load;

    // Walk from the output back: a stage frees up when whatever sits below it takes its data.
    always_comb begin
        w_up      = '0;
        w_load    = '0;
        w_unload  = '0;
        w_up[0]   = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            w_up[k] = w_valid[k-1];
        end
        w_dn_load = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_unload[k] = w_valid[k] & w_dn_load;
            w_load[k]   = (~w_valid[k] | w_unload[k]) & w_up[k];
            w_dn_load   = w_load[k];
        end
    end

    assign in_ready = ~w_valid[0] | w_unload[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t         w_src;
        stage_t         w_next;
        logic [S-1:0]   w_slice_sum;
        stage_t         r_stage;

        if (k == 0) begin : g_src_in
            assign w_src = '{valid: 1'b1, carry: c_in, psum: '0, a: in1, b: in2};
        end else begin : g_src_prev
            assign w_src = g_stage[k-1].r_stage;
        end

        for (genvar g = 0; g < NG; g++) begin : g_grp
            logic w_cin;
            logic w_cout;

            if (g == 0) begin : g_first
                assign w_cin = w_src.carry;
            end else begin : g_chain
                assign w_cin = g_grp[g-1].w_cout;
            end

            carry_bypass_block #(
                .BLOCK_W (BLOCK_W)
            ) u_blk (
                .a    (w_src.a[k*S + g*BLOCK_W +: BLOCK_W]),
                .b    (w_src.b[k*S + g*BLOCK_W +: BLOCK_W]),
                .cin  (w_cin),
                .s    (w_slice_sum[g*BLOCK_W +: BLOCK_W]),
                .cout (w_cout)
            );
        end

        always_comb begin
            w_next                 = w_src;
            w_next.valid           = 1'b1;
            w_next.carry           = g_grp[NG-1].w_cout;
            w_next.psum[k*S +: S]  = w_slice_sum;
        end

        // Data only moves on a load, so idle operand values never reach a valid record.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_stage <= '0;
            end else if (w_load[k]) begin
                r_stage <= w_next;
            end else if (w_unload[k]) begin
                r_stage.valid <= 1'b0;
            end
        end

        assign w_valid[k] = r_stage.valid;
    end

    assign out_valid = g_stage[STAGES-1].r_stage.valid;
    assign sum       = g_stage[STAGES-1].r_stage.psum;
    assign c_out     = g_stage[STAGES-1].r_stage.carry;

`ifdef CBA_SIGNED_OVERFLOW_EN
    assign overflow = (g_stage[STAGES-1].r_stage.a[WIDTH-1] == g_stage[STAGES-1].r_stage.b[WIDTH-1])
                   && (g_stage[STAGES-1].r_stage.psum[WIDTH-1] != g_stage[STAGES-1].r_stage.a[WIDTH-1]);
`endif

    logic w_unused_bits;
    assign w_unused_bits = ^{g_stage[STAGES-1].r_stage.a, g_stage[STAGES-1].r_stage.b};

endmodule

// File: tb/tb_pipelined_carry_bypass_adder.sv
// tb/tb_pipelined_carry_bypass_adder.sv - directed and random scoreboard bench for pipelined_carry_bypass_adder
module tb_pipelined_carry_bypass_adder;

    localparam int W  = 32;
    localparam int BW = 4;
    localparam int ST = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         c_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         c_out;
`ifdef CBA_SIGNED_OVERFLOW_EN
    logic         overflow;
`endif

    always #5 clk = ~clk;

    pipelined_carry_bypass_adder #(
        .WIDTH   (W),
        .BLOCK_W (BW),
        .STAGES  (ST)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef CBA_SIGNED_OVERFLOW_EN
        ,
        .overflow  (overflow)
`endif
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    int         n_out  = 0;
    logic [W:0] q_res [$];
    logic       q_ovf [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width arithmetic with one extra bit for the carry out.
    task automatic cycle();
        logic [W:0] e;
        logic       eo;
        #1;
        if (out_valid && out_ready) begin
            if (q_res.size() == 0) begin
                check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e  = q_res.pop_front();
                eo = q_ovf.pop_front();
                check("sum", 64'(sum), 64'(e[W-1:0]));
                check("c_out", 64'(c_out), 64'(e[W]));
`ifdef CBA_SIGNED_OVERFLOW_EN
                check("overflow", 64'(overflow), 64'(eo));
`endif
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            e  = {1'b0, in1} + {1'b0, in2} + {{W{1'b0}}, c_in};
            eo = (in1[W-1] == in2[W-1]) && (e[W-1] != in1[W-1]);
            q_res.push_back(e);
            q_ovf.push_back(eo);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        int   n;
        logic ok;
        n        = 0;
        in1      = a;
        in2      = b;
        c_in     = c;
        in_valid = 1'b1;
        do begin
            #1;
            ok = in_ready;
            cycle();
            n++;
        end while (!ok && n < 50);
        if (!ok) check("send_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q_res.size() != 0 && n < 100) begin
            cycle();
            n++;
        end
        check("drain_empty", 64'(q_res.size()), 64'd0);
        check("idle_after_drain", 64'(out_valid), 64'd0);
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int         n;
        int         n0;
        int         accepted;
        logic       have_ref;
        logic [W-1:0] ref_sum;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        c_in      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_c_out", 64'(c_out), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Latency for the all-ones add.
        out_ready = 1'b1;
        send('1, '1, 1'b0);
        n = 1;
        while (!out_valid && n < 20) begin
            cycle();
            n++;
        end
        check("latency", 64'(n), 64'(ST));
        cycle();

        send('1, '0, 1'b1);
        send(32'hFFFF_FFF6, 32'hFFFF_FFFB, 1'b0);
        drain();

        // Back-to-back stream, never stalled.
        n0 = n_out;
        n  = 0;
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 10; i++) begin
                for (int j = 0; j < 10; j++) begin
                    in1      = W'(i);
                    in2      = W'(j);
                    c_in     = c[0];
                    in_valid = 1'b1;
                    #1;
                    check("stream_in_ready", 64'(in_ready), 64'd1);
                    if (n >= ST) check("stream_out_valid", 64'(out_valid), 64'd1);
                    cycle();
                    n++;
                end
            end
        end
        drain();
        check("stream_count", 64'(n_out - n0), 64'd200);

        // Full stall: pipe fills, in_ready drops, output holds.
        out_ready = 1'b0;
        accepted  = 0;
        have_ref  = 1'b0;
        ref_sum   = '0;
        for (int t = 0; t < 5; t++) begin
            in1      = rand_op();
            in2      = rand_op();
            c_in     = 1'($urandom);
            in_valid = 1'b1;
            #1;
            check("stall_in_ready", 64'(in_ready), 64'(accepted < ST));
            if (in_ready) accepted++;
            if (out_valid) begin
                if (have_ref) check("stall_sum_stable", 64'(sum), 64'(ref_sum));
                else begin
                    ref_sum  = sum;
                    have_ref = 1'b1;
                end
            end
            cycle();
        end
        drain();

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(rand_op(), rand_op(), 1'b1);
        send(rand_op(), rand_op(), 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check("midrst_c_out", 64'(c_out), 64'd0);
`ifdef CBA_SIGNED_OVERFLOW_EN
        check("midrst_overflow", 64'(overflow), 64'd0);
`endif
        q_res.delete();
        q_ovf.delete();
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            check("post_rst_idle", 64'(out_valid), 64'd0);
            cycle();
        end

        // Random traffic with random backpressure.
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in1       = rand_op();
            in2       = rand_op();
            c_in      = 1'($urandom);
            cycle();
        end
        drain();

`ifdef CBA_SIGNED_OVERFLOW_EN
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        send(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        send(32'h0000_0005, 32'hFFFF_FFF6, 1'b0);
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_carry_bypass_adder.md
Name: pipelined_carry_bypass_adder

Overview:
Parametrised, pipelined successor to the 32-bit combinational carry-bypass adder. Splits a WIDTH-bit add of in1 + in2 + c_in into STAGES register-separated slices, each built from BLOCK_W-bit carry-bypass groups. Carry and unprocessed operand bits travel down the pipe. Valid/ready handshakes with backpressure and bubble collapsing let it sit directly in the datapath between elastic producers and consumers.

Parameters:
WIDTH, 32, operand and sum width in bits.
BLOCK_W, 4, bits per carry-bypass group; ripple inside the group, bypass mux on the group propagate.
STAGES, 2, pipeline slices and latency in cycles; WIDTH must be divisible by BLOCK_W*STAGES (elaboration-time check, fatal on violation).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operands presented.
in_ready  output  1  adder accepts operands this cycle.
in1  input  WIDTH  operand A (two's complement or unsigned; the add is identical).
in2  input  WIDTH  operand B.
c_in  input  1  carry in.
out_valid  output  1  result held on the outputs.
out_ready  input  1  consumer accepts result.
sum  output  WIDTH  in1+in2+c_in mod 2^WIDTH.
c_out  output  1  carry out of the MSB (unsigned overflow).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: at the first clk edge with rst=1, all stage valid bits clear. out_valid=0, sum=0, c_out=0. in_ready=1 from the cycle after reset.
- Reset mid-operation: all in-flight transactions are dropped. No output is produced for them.
- Transfers:
  - An input transfer occurs when in_valid and in_ready are both 1 at a clk edge.
  - An output transfer occurs when out_valid and out_ready are both 1 at a clk edge.
- Stage k (0..STAGES-1):
  - Adds bits [k*S +: S], where S=WIDTH/STAGES, using the carry from stage k-1 (c_in for stage 0).
  - Registers the partial sum, the carry, and the untouched upper operand bits.
- Group carry: cout_g = P_g ? cin_g : ripple_cout_g, where P_g = AND of (a_i XOR b_i) over the group.
- Latency:
  - Exactly STAGES cycles from input transfer to out_valid when there is no backpressure.
  - Throughput is 1 result per cycle.
- Advance rule: stage k loads when stage k is empty or stage k is unloading. Stage k unloads when stage k+1 is loading; the last stage unloads on an output transfer.
- in_ready = stage 0 empty or stage 0 unloading (combinational).
- Bubbles collapse: an empty stage loads even while downstream stages are stalled.
- Full stall: with out_valid=1 and out_ready=0, sum and c_out hold stable. in_ready drops once every stage is full, which takes at most STAGES cycles.
- Simultaneous input and output transfer in the same cycle: both occur, with no loss or duplication.
- Order is strictly FIFO; no reordering.
- Wrap-around: the result is always mod 2^WIDTH. c_out carries the lost bit.
- No X propagation: when in_valid=0, operand values do not affect any state except registers whose valid bit is 0.

Optional Feature:
Macro CBA_SIGNED_OVERFLOW_EN.
- Defined:
  - Adds an output port overflow (1 bit, reset 0).
  - overflow = (in1[MSB]==in2[MSB]) && (sum[MSB]!=in1[MSB]).
  - Operand MSBs are pipelined alongside the data so that overflow is aligned with sum and holds under stall.
- Undefined: no port, no extra registers.

Decomposition:
- Package cba_pkg: localparam helper functions NUM_GROUPS(WIDTH,BLOCK_W) and SLICE_W(WIDTH,STAGES); typedef struct stage_t {valid, carry, partial sum, remaining operand bits}, sized by parameters through a parametrised class or macro.
- Sub-module carry_bypass_block:
  - Parameter BLOCK_W; inputs a, b, cin; outputs s, cout; purely combinational.
  - Instantiated SLICE_W/BLOCK_W times per stage.
  - Also unit-testable in isolation.

Test Plan:
- Default params, in1=0xFFFFFFFF, in2=0xFFFFFFFF, c_in=0 -> sum=0xFFFFFFFE, c_out=1, out_valid exactly 2 cycles after acceptance.
- in1=0xFFFFFFFF, in2=0, c_in=1 (full bypass chain) -> sum=0x00000000, c_out=1. Then in1=0xFFFFFFF6 (-10), in2=0xFFFFFFFB (-5), c_in=0 -> sum=0xFFFFFFF1 (-15), c_out=1.
- Stream i+j for i,j in 0..9 and c_in in 0..1, back to back with out_ready=1 -> 200 results in order, one per cycle, each equal to i+j+c_in, c_out=0.
- Hold out_ready=0 for 5 cycles during a stream -> in_ready falls after 2 further accepts, sum stays stable. Release -> no loss or duplication; scoreboard matches.
- Assert rst for one cycle with 2 transactions in flight -> out_valid=0, sum=0, c_out=0 next cycle; the dropped transactions never appear.
- With CBA_SIGNED_OVERFLOW_EN: 0x7FFFFFFF + 1 -> overflow=1, c_out=0. 0x80000000 + 0xFFFFFFFF -> overflow=1, c_out=1. 5 + (-10) -> overflow=0. Repeat with WIDTH=16, BLOCK_W=2, STAGES=4.
